half_adder_pipe: RTL and testbench

- Registered, flow-controlled array of WIDTH independent one-bit half adders. Each lane computes sum = a XOR b and carry = a AND b.
- Results are delivered on a valid/ready output stream with one cycle of latency.
- An internal skid buffer sustains one result per cycle under backpressure.
- Used wherever a pipelined bitwise half-add stage is needed between streaming blocks.

---
 rtl/half_adder_pipe_if.sv | 24 ++
 rtl/half_adder_pipe.sv | 86 ++++++++
 tb/tb_half_adder_pipe.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/half_adder_pipe_if.sv
// Operand/result stream bundle for half_adder_pipe.
// The slave modport is the adder's view; master is the upstream/downstream side.
interface half_adder_pipe_if #(
    parameter int unsigned WIDTH = 1
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] carry;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, sum, carry
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, sum, carry
    );
endinterface

// File: rtl/half_adder_pipe.sv
// Registered array of independent half adders with a one-entry skid buffer,
// sustaining one result per cycle on a valid/ready stream.
module half_adder_pipe #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    half_adder_pipe_if.slave   bus,
    output logic [CNT_W-1:0]   op_count
);
    // Occupancy: nothing held, output register loaded, output and skid loaded.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_OUT   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [2*WIDTH-1:0]     out_q, out_d;
    logic [2*WIDTH-1:0]     skid_q, skid_d;
    logic                   in_ready_q;
    logic                   accept;
    logic                   drain;
    logic [2*WIDTH-1:0]     result;

    // Packed as {carry, sum}
    assign result = {bus.a & bus.b, bus.a ^ bus.b};
    assign accept = bus.in_valid & in_ready_q;
    assign drain  = (state_q != S_EMPTY) & bus.out_ready;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        case (state_q)
            S_EMPTY: begin
                if (accept) begin
                    out_d   = result;
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (accept && drain) begin
                    out_d = result;
                end else if (accept) begin
                    skid_d  = result;
                    state_d = S_FULL;
                end else if (drain) begin
                    state_d = S_EMPTY;
                end
            end
            S_FULL: begin
                // in_ready is low here, so only the drain path can fire
                if (drain) begin
                    out_d   = skid_q;
                    state_d = S_OUT;
                end
            end
            default: state_d = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_EMPTY;
            out_q      <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b0;
            op_count   <= '0;
        end else begin
            state_q    <= state_d;
            out_q      <= out_d;
            skid_q     <= skid_d;
            in_ready_q <= (state_d != S_FULL);
            if (drain) begin
                op_count <= op_count + CNT_W'(1);
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = (state_q != S_EMPTY);
    assign bus.sum       = out_q[WIDTH-1:0];
    assign bus.carry     = out_q[2*WIDTH-1:WIDTH];
endmodule

// File: tb/tb_half_adder_pipe.sv
// Self-checking bench for half_adder_pipe: directed steps plus a scoreboard
// monitor on an 8-lane instance, and a 1-lane instance for the truth table.
module tb_half_adder_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  cnt8;
    logic [15:0] cnt1;
    int          n_pass = 0;
    int          n_fail = 0;
    int          exp_count = 0;
    logic [15:0] sb[$];

    half_adder_pipe_if #(.WIDTH(8)) bus ();
    half_adder_pipe_if #(.WIDTH(1)) bus1 ();

    half_adder_pipe #(.WIDTH(8), .CNT_W(2)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .op_count (cnt8)
    );

    half_adder_pipe #(.WIDTH(1), .CNT_W(16)) u_dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus1),
        .op_count (cnt1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor for the 8-lane instance, sampled on the falling edge
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_count = 0;
        end else begin
            check("op_count", 32'(cnt8), 32'(exp_count % 4));
            if (bus.out_valid) begin
                if (sb.size() == 0) begin
                    check("out_valid_no_pending", {31'b0, bus.out_valid}, 32'd0);
                end else begin
                    check("result", {16'b0, bus.carry, bus.sum}, {16'b0, sb[0]});
                    if (bus.out_ready) begin
                        void'(sb.pop_front());
                        exp_count++;
                    end
                end
            end
            if (bus.in_valid && bus.in_ready)
                sb.push_back({bus.a & bus.b, bus.a ^ bus.b});
        end
    end

    initial begin
        logic [1:0] tt_exp [4];
        int         wrap_seq [5];
        logic [1:0] ab;
        int         waited;

        tt_exp   = '{2'b00, 2'b01, 2'b01, 2'b10};
        wrap_seq = '{1, 2, 3, 0, 1};

        bus.in_valid  = 1'b0; bus.a  = '0; bus.b  = '0; bus.out_ready  = 1'b1;
        bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.out_ready = 1'b1;

        // Reset state
        #2;
        check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
        check("rst_sum", {24'b0, bus.sum}, 32'd0);
        check("rst_carry", {24'b0, bus.carry}, 32'd0);
        check("rst_count", {30'b0, cnt8}, 32'd0);
        check("rst_in_ready1", {31'b0, bus1.in_ready}, 32'd0);
        #20;
        rst_n = 1'b1;
        step();
        check("in_ready_after_rst", {31'b0, bus.in_ready}, 32'd1);
        check("in_ready_after_rst1", {31'b0, bus1.in_ready}, 32'd1);

        // Truth table on the 1-lane instance, back-to-back with out_ready=1
        bus1.in_valid = 1'b1; bus1.a = 1'b0; bus1.b = 1'b0;
        step();
        for (int i = 1; i <= 4; i++) begin
            check("tt_valid", {31'b0, bus1.out_valid}, 32'd1);
            check("tt_result", {30'b0, bus1.carry, bus1.sum}, {30'b0, tt_exp[i-1]});
            if (i < 4) begin
                ab = 2'(i);
                bus1.a = ab[1];
                bus1.b = ab[0];
            end else begin
                bus1.in_valid = 1'b0;
            end
            step();
        end
        check("tt_count", {16'b0, cnt1}, 32'd4);
        check("tt_drained", {31'b0, bus1.out_valid}, 32'd0);

        // Single 8-lane transfer
        bus.in_valid = 1'b1; bus.a = 8'hF0; bus.b = 8'hAA;
        step();
        bus.in_valid = 1'b0;
        check("single_valid", {31'b0, bus.out_valid}, 32'd1);
        check("single_sum", {24'b0, bus.sum}, 32'h5A);
        check("single_carry", {24'b0, bus.carry}, 32'hA0);
        step();
        check("single_one_cycle", {31'b0, bus.out_valid}, 32'd0);

        // Backpressure: two accepted, third held off
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.a = 8'h0F; bus.b = 8'h33;
        step();
        bus.a = 8'hC3; bus.b = 8'h5A;
        step();
        check("bp_in_ready_low", {31'b0, bus.in_ready}, 32'd0);
        bus.a = 8'hFF; bus.b = 8'h81;
        step();
        check("bp_in_ready_held", {31'b0, bus.in_ready}, 32'd0);
        check("bp_sum_pair1", {24'b0, bus.sum}, 32'h3C);
        step();
        check("bp_carry_pair1", {24'b0, bus.carry}, 32'h03);
        bus.out_ready = 1'b1;
        step();
        check("bp_in_ready_back", {31'b0, bus.in_ready}, 32'd1);
        check("bp_sum_pair2", {24'b0, bus.sum}, 32'h99);
        step();
        bus.in_valid = 1'b0;
        check("bp_sum_pair3", {24'b0, bus.sum}, 32'h7E);
        check("bp_carry_pair3", {24'b0, bus.carry}, 32'h81);
        step();
        check("bp_drained", {31'b0, bus.out_valid}, 32'd0);

        // Asynchronous reset with the skid buffer full
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.a = 8'h12; bus.b = 8'h34;
        step();
        bus.a = 8'h56; bus.b = 8'h78;
        step();
        bus.in_valid = 1'b0;
        check("skid_full", {31'b0, bus.in_ready}, 32'd0);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("arst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("arst_sum", {24'b0, bus.sum}, 32'd0);
        check("arst_carry", {24'b0, bus.carry}, 32'd0);
        check("arst_in_ready", {31'b0, bus.in_ready}, 32'd0);
        check("arst_count1", {16'b0, cnt1}, 32'd0);
        #4;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        step();
        check("post_rst_in_ready", {31'b0, bus.in_ready}, 32'd1);

        // First pair after reset, then op_count wrap with CNT_W=2
        bus.in_valid = 1'b1; bus.a = 8'h3C; bus.b = 8'h0F;
        step();
        check("post_rst_sum", {24'b0, bus.sum}, 32'h33);
        check("post_rst_carry", {24'b0, bus.carry}, 32'h0C);
        for (int k = 1; k <= 5; k++) begin
            if (k < 5) begin
                bus.a = 8'($urandom);
                bus.b = 8'($urandom);
            end else begin
                bus.in_valid = 1'b0;
            end
            step();
            check("wrap_count", {30'b0, cnt8}, 32'(wrap_seq[k-1]));
        end

        // Random traffic, checked by the scoreboard monitor
        for (int n = 0; n < 1000; n++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.a         = 8'($urandom);
            bus.b         = 8'($urandom);
            bus.out_ready = 1'($urandom_range(0, 1));
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        waited = 0;
        while (sb.size() != 0 && waited < 10) begin
            step();
            waited++;
        end
        step();
        check("drain_empty", 32'(sb.size()), 32'd0);
        check("drain_out_valid", {31'b0, bus.out_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
        $finish;
    end
endmodule
